// File: rtl/alu_pkg.sv
// Shared ALU definitions: 3-bit opcode constants used by the ALU control unit
// and the multiply sequencer, plus the sequencer state encoding.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_ROR = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_ROL = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'b111;

  localparam int unsigned SEQ_CNT_W = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ADD   = 2'd1,
    SEQ_SHIFT = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle shift-and-add multiplier that borrows the shared ALU (ADD and SLL
// only) and stalls the pipeline while running. Returns the low WIDTH bits.
// Optional macro ALU_MULT_SEQUENCER_EARLY_EXIT_EN: skip remaining iterations
// once the multiplier is exhausted, and finish immediately when opB is zero.
module alu_mult_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    opA,
  input  logic [WIDTH-1:0]    opB,
  input  logic [WIDTH-1:0]    alu_out,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                alu_own,
  output logic [WIDTH-1:0]    alu_A,
  output logic [WIDTH-1:0]    alu_B,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_invA,
  output logic                alu_invB,
  output logic                alu_Cin,
  output logic                alu_sign
);

`ifdef ALU_MULT_SEQUENCER_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [SEQ_CNT_W-1:0] CNT_LAST = SEQ_CNT_W'(15);

  seq_state_e           state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [SEQ_CNT_W-1:0] cnt_q, cnt_d;

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEQ_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, datapath update and ALU drive; result is loaded on the edge
  // that enters DONE so it is already valid during the done pulse.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    busy     = 1'b1;
    done     = 1'b0;
    alu_own  = 1'b0;
    alu_A    = '0;
    alu_B    = '0;
    alu_op   = ALU_ADD;
    alu_invA = 1'b0;
    alu_invB = 1'b0;
    alu_Cin  = 1'b0;
    alu_sign = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        busy = 1'b0;
        if (start) begin
          mcand_d  = opA;
          mplier_d = opB;
          acc_d    = '0;
          cnt_d    = '0;
          if (EARLY_EXIT && (opB == '0)) begin
            state_d  = SEQ_DONE;
            result_d = '0;
          end else if (opB[0]) begin
            state_d = SEQ_ADD;
          end else begin
            state_d = SEQ_SHIFT;
          end
        end
      end

      SEQ_ADD: begin
        alu_own = 1'b1;
        alu_A   = acc_q;
        alu_B   = mcand_q;
        alu_op  = ALU_ADD;
        acc_d   = alu_out;
        state_d = SEQ_SHIFT;
      end

      SEQ_SHIFT: begin
        alu_own  = 1'b1;
        alu_A    = mcand_q;
        alu_B    = WIDTH'(1);
        alu_op   = ALU_SLL;
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SEQ_CNT_W'(1);
        if ((cnt_q == CNT_LAST) || (EARLY_EXIT && ((mplier_q >> 1) == '0))) begin
          state_d  = SEQ_DONE;
          result_d = acc_q;
        end else if (mplier_q[1]) begin
          state_d = SEQ_ADD;
        end else begin
          state_d = SEQ_SHIFT;
        end
      end

      SEQ_DONE: begin
        done    = 1'b1;
        state_d = SEQ_IDLE;
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer with a behavioural ALU model.
module tb_alu_mult_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] opA, opB, alu_out;
  logic        busy, done, alu_own;
  logic [15:0] result, alu_A, alu_B;
  logic [2:0]  alu_op;
  logic        alu_invA, alu_invB, alu_Cin, alu_sign;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_mult_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opA(opA), .opB(opB),
    .alu_out(alu_out), .busy(busy), .done(done), .result(result),
    .alu_own(alu_own), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_Cin(alu_Cin),
    .alu_sign(alu_sign)
  );

  // Behavioural shared ALU: only ADD and SLL matter here.
  assign alu_out = (alu_op == 3'b000) ? 16'(alu_A + alu_B) :
                   (alu_op == 3'b111) ? 16'(alu_A << alu_B) : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] b);
    int pc;
    int msb;
    pc  = 0;
    msb = -1;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        pc++;
        msb = i;
      end
    end
`ifdef ALU_MULT_SEQUENCER_EARLY_EXIT_EN
    if (b == 16'h0000) return 1;
    return 2 + pc + msb;
`else
    return 17 + pc;
`endif
  endfunction

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit hold);
    exp_t        e;
    logic [31:0] full;
    logic [15:0] acc_m, mcand_m;
    int          cyc, own_cnt;
    bit          seen;
    wait_idle();
    start = 1'b1;
    opA   = a;
    opB   = b;
    full  = 32'(a) * 32'(b);
    e.prod = full[15:0];
    e.lat  = exp_lat(b);
    sb.push_back(e);
    acc_m   = 16'h0000;
    mcand_m = a;
    own_cnt = 0;
    seen    = 1'b0;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      check_eq("busy_run", 32'(busy), 32'd1);
      if (alu_own) begin
        own_cnt++;
        check_eq("alu_mods", 32'({alu_invA, alu_invB, alu_Cin, alu_sign}), 32'd0);
        if (alu_op == 3'b000) begin
          check_eq("add_A", 32'(alu_A), 32'(acc_m));
          check_eq("add_B", 32'(alu_B), 32'(mcand_m));
          acc_m = 16'(acc_m + mcand_m);
        end else begin
          check_eq("shift_op", 32'(alu_op), 32'd7);
          check_eq("shift_A", 32'(alu_A), 32'(mcand_m));
          check_eq("shift_B", 32'(alu_B), 32'd1);
          mcand_m = 16'(mcand_m << 1);
        end
      end else if (!done) begin
        check_eq("unexpected_stall", 32'(alu_own), 32'd1);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    e = sb.pop_front();
    if (!seen) begin
      check_eq("done_timeout", 32'(seen), 32'd1);
    end else begin
      check_eq("latency", 32'(cyc), 32'(e.lat));
      check_eq("result", 32'(result), 32'(e.prod));
      check_eq("result_vs_alu", 32'(result), 32'(acc_m));
      check_eq("own_cycles", 32'(own_cnt), 32'(e.lat - 1));
      check_eq("idle_alu", 32'({alu_own, alu_A, alu_B, alu_op}), 32'd0);
      @(posedge clk);
      #1;
      check_eq("busy_fall", 32'(busy), 32'd0);
      check_eq("done_pulse", 32'(done), 32'd0);
      check_eq("result_hold", 32'(result), 32'(e.prod));
    end
  endtask

  initial begin
    int dc;
    rst   = 1'b1;
    start = 1'b0;
    opA   = 16'h0000;
    opB   = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_alu", 32'({alu_own, alu_A, alu_B, alu_op, alu_invA, alu_invB, alu_Cin, alu_sign}), 32'd0);
    rst = 1'b0;

    run_op(16'd300, 16'd300, 1'b0);
    check_eq("wrap_300x300", 32'(result), 32'h5F90);
    run_op(16'hFFFD, 16'd5, 1'b0);
    check_eq("neg3x5", 32'(result), 32'hFFF1);
    run_op(16'd5, 16'hFFFD, 1'b0);
    check_eq("5xneg3", 32'(result), 32'hFFF1);
    run_op(16'h1234, 16'h0000, 1'b0);
    check_eq("times_zero", 32'(result), 32'd0);
    run_op(16'hABCD, 16'd1, 1'b0);
    run_op(16'h0003, 16'hFFFF, 1'b0);
    run_op(16'hFFFF, 16'h8000, 1'b0);

    // start held high: second op accepted right after the first returns to IDLE
    run_op(16'd5, 16'd3, 1'b1);
    check_eq("hold_first", 32'(result), 32'd15);
    run_op(16'd5, 16'd3, 1'b0);
    check_eq("hold_second", 32'(result), 32'd15);
    start = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'b0);
    end

    // reset mid-operation
    wait_idle();
    start = 1'b1;
    opA   = 16'd7;
    opB   = 16'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_own", 32'(alu_own), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_result", 32'(result), 32'd0);
    dc = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    check_eq("abort_no_done", 32'(dc), 32'd0);
    run_op(16'd3, 16'd4, 1'b0);
    check_eq("after_abort", 32'(result), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
